// File: rtl/if_fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_stage_pkg
//   Shared definitions for the fetch stage and its skid buffer:
//   FSM state encoding, default reset PC / bubble instruction, the skid
//   entry layout and the modulo-2^32 PC increment.
// ---------------------------------------------------------------------------
package if_fetch_stage_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HELD  = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
   } skid_entry_t;

   // Wraps naturally: 32'hFFFF_FFFC + 4 = 0.
   function automatic logic [31:0] pc_inc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/if_fetch_stage_skid_buf.sv
// ---------------------------------------------------------------------------
// fetch_skid_buf
//   One-entry {instr, pc4} holding register for a word that arrived while
//   the pipe was held.
//   Ports:
//     clk    in   clock, rising edge
//     rst    in   synchronous active-high reset, empties the entry
//     load   in   capture din, set full
//     clear  in   drop the entry, clear full (wins over load)
//     din    in   {instr, pc4} to capture
//     dout   out  stored {instr, pc4}
//     full   out  entry holds a word
// ---------------------------------------------------------------------------
module fetch_skid_buf
   import if_fetch_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        clear,
   input  skid_entry_t din,
   output skid_entry_t dout,
   output logic        full
);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         full <= 1'b0;
         dout <= '0;
      end else if (load) begin
         full <= 1'b1;
         dout <= din;
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//   Fetch stage plus IF/ID pipeline register of the 5-stage MIPS core.
//   Honours load-use stalls, branch/jump redirects from ID and wait states
//   on the instruction-memory req/ready handshake.
//   Ports:
//     clk, rst              clock / synchronous active-high reset
//     pc_write, IF_ID_write stall requests from hazard unit (1 = stall)
//     redirect_valid/pc     taken branch/jump target from ID
//     imem_req/addr         fetch request and address
//     imem_ready/rdata      response; transfer = imem_req && imem_ready
//     ID_instr/pc4/valid    IF/ID register contents (valid=0 is a bubble)
// ---------------------------------------------------------------------------
module if_fetch_stage
   import if_fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
   parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_write,
   input  logic        IF_ID_write,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ID_instr,
   output logic [31:0] ID_pc4,
   output logic        ID_valid
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic [31:0]  req_addr;
   logic [31:0]  pc_plus4;
   logic         hold;
   logic         transfer;
   logic         skid_load;
   logic         skid_clear;
   logic         skid_full;
   skid_entry_t  skid_din;
   skid_entry_t  skid_q;

   assign hold      = pc_write | IF_ID_write;
   assign pc_plus4  = pc_inc(pc);
   assign imem_req  = !rst && (state != HELD);
   // DRAIN keeps presenting the abandoned address until memory completes it.
   assign imem_addr = (state == DRAIN) ? req_addr : pc;
   assign transfer  = imem_req && imem_ready;

   assign skid_din   = '{instr: imem_rdata, pc4: pc_plus4};
   assign skid_load  = (state == FETCH) && !redirect_valid && transfer && hold;
   assign skid_clear = (state == HELD) && (redirect_valid || !hold);

   fetch_skid_buf u_skid (
      .clk   (clk),
      .rst   (rst),
      .load  (skid_load),
      .clear (skid_clear),
      .din   (skid_din),
      .dout  (skid_q),
      .full  (skid_full)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= FETCH;
         pc       <= RESET_PC;
         req_addr <= RESET_PC;
         ID_instr <= NOP_INSTR;
         ID_pc4   <= '0;
         ID_valid <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               req_addr <= pc;
               if (redirect_valid) begin
                  // Any word arriving now belongs to the wrong path.
                  pc       <= redirect_pc;
                  ID_instr <= NOP_INSTR;
                  ID_valid <= 1'b0;
                  if (!imem_ready) state <= DRAIN;
               end else if (transfer && !hold) begin
                  ID_instr <= imem_rdata;
                  ID_pc4   <= pc_plus4;
                  ID_valid <= 1'b1;
                  pc       <= pc_plus4;
               end else if (transfer) begin
                  // Word parked in the skid buffer; stop requesting.
                  pc    <= pc_plus4;
                  state <= HELD;
               end else if (!hold) begin
                  ID_instr <= NOP_INSTR;
                  ID_valid <= 1'b0;
               end
            end
            HELD: begin
               if (redirect_valid) begin
                  pc       <= redirect_pc;
                  ID_instr <= NOP_INSTR;
                  ID_valid <= 1'b0;
                  state    <= FETCH;
               end else if (!hold) begin
                  ID_instr <= skid_q.instr;
                  ID_pc4   <= skid_q.pc4;
                  ID_valid <= skid_full;
                  state    <= FETCH;
               end
            end
            DRAIN: begin
               if (redirect_valid) pc <= redirect_pc;
               if (!hold) begin
                  ID_instr <= NOP_INSTR;
                  ID_valid <= 1'b0;
               end
               if (imem_ready) state <= FETCH;
            end
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
//   Directed bench for if_fetch_stage. Instruction memory returns
//   addr | 32'hA000_0000 so every delivered word identifies its address.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

   logic        clk;
   logic        rst;
   logic        pc_write;
   logic        IF_ID_write;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] ID_instr;
   logic [31:0] ID_pc4;
   logic        ID_valid;

   int unsigned errors = 0;
   int unsigned checks = 0;

   if_fetch_stage #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (32'h0000_0000)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .pc_write       (pc_write),
      .IF_ID_write    (IF_ID_write),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rdata     (imem_rdata),
      .ID_instr       (ID_instr),
      .ID_pc4         (ID_pc4),
      .ID_valid       (ID_valid)
   );

   assign imem_rdata = imem_addr | 32'hA000_0000;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_hold(input logic h);
      pc_write    = h;
      IF_ID_write = h;
   endtask

   initial begin
      rst            = 1'b1;
      set_hold(1'b0);
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_ready     = 1'b1;

      // 1. reset and streaming
      tick();
      tick();
      chk("rst_valid", {31'd0, ID_valid}, 32'd0);
      chk("rst_instr", ID_instr, 32'h0);
      chk("rst_pc4",   ID_pc4,   32'h0);
      chk("rst_req",   {31'd0, imem_req}, 32'd0);
      rst = 1'b0;
      #1;
      chk("start_req",  {31'd0, imem_req}, 32'd1);
      chk("start_addr", imem_addr, 32'h0);
      tick();
      chk("s1_pc4", ID_pc4, 32'd4);
      chk("s1_ins", ID_instr, 32'hA000_0000);
      chk("s1_val", {31'd0, ID_valid}, 32'd1);
      tick();
      chk("s2_pc4", ID_pc4, 32'd8);
      chk("s2_ins", ID_instr, 32'hA000_0004);
      tick();
      chk("s3_pc4", ID_pc4, 32'd12);
      chk("s3_ins", ID_instr, 32'hA000_0008);

      // 2. two-cycle stall while streaming: word at 12 goes to skid
      set_hold(1'b1);
      tick();
      chk("h1_pc4", ID_pc4, 32'd12);
      chk("h1_req", {31'd0, imem_req}, 32'd0);
      tick();
      chk("h2_pc4", ID_pc4, 32'd12);
      chk("h2_ins", ID_instr, 32'hA000_0008);
      chk("h2_req", {31'd0, imem_req}, 32'd0);
      set_hold(1'b0);
      tick();
      chk("rel1_pc4", ID_pc4, 32'd16);
      chk("rel1_ins", ID_instr, 32'hA000_000C);
      chk("rel1_val", {31'd0, ID_valid}, 32'd1);
      tick();
      chk("rel2_pc4", ID_pc4, 32'd20);
      chk("rel2_ins", ID_instr, 32'hA000_0010);

      // 3. redirect while streaming
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      tick();
      redirect_valid = 1'b0;
      chk("rd_val",  {31'd0, ID_valid}, 32'd0);
      chk("rd_ins",  ID_instr, 32'h0);
      chk("rd_pc4",  ID_pc4, 32'd20);
      chk("rd_addr", imem_addr, 32'h100);
      tick();
      chk("rd2_pc4", ID_pc4, 32'h104);
      chk("rd2_ins", ID_instr, 32'hA000_0100);
      chk("rd2_val", {31'd0, ID_valid}, 32'd1);

      // 4. three wait states at 0x20
      redirect_valid = 1'b1;
      redirect_pc    = 32'h20;
      tick();
      redirect_valid = 1'b0;
      imem_ready     = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("ws_addr", imem_addr, 32'h20);
         chk("ws_val",  {31'd0, ID_valid}, 32'd0);
      end
      imem_ready = 1'b1;
      tick();
      chk("ws_pc4", ID_pc4, 32'h24);
      chk("ws_ins", ID_instr, 32'hA000_0020);
      chk("ws_v",   {31'd0, ID_valid}, 32'd1);

      // 5. redirect to 0x200 while 0x40 is outstanding
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      tick();
      imem_ready  = 1'b0;
      redirect_pc = 32'h200;
      tick();
      redirect_valid = 1'b0;
      chk("dr_addr0", imem_addr, 32'h40);
      chk("dr_req0",  {31'd0, imem_req}, 32'd1);
      chk("dr_val0",  {31'd0, ID_valid}, 32'd0);
      tick();
      chk("dr_addr1", imem_addr, 32'h40);
      chk("dr_val1",  {31'd0, ID_valid}, 32'd0);
      imem_ready = 1'b1;
      tick();
      chk("dr_val2",  {31'd0, ID_valid}, 32'd0);
      chk("dr_ins2",  ID_instr, 32'h0);
      chk("dr_addr2", imem_addr, 32'h200);
      tick();
      chk("dr_pc4", ID_pc4, 32'h204);
      chk("dr_ins", ID_instr, 32'hA000_0200);

      // 6. reset while HELD with skid full
      set_hold(1'b1);
      tick();
      chk("hr_req", {31'd0, imem_req}, 32'd0);
      chk("hr_val", {31'd0, ID_valid}, 32'd1);
      rst = 1'b1;
      tick();
      chk("hr_rval", {31'd0, ID_valid}, 32'd0);
      chk("hr_rreq", {31'd0, imem_req}, 32'd0);
      chk("hr_rpc4", ID_pc4, 32'h0);
      rst = 1'b0;
      set_hold(1'b0);
      #1;
      chk("hr_addr", imem_addr, 32'h0);
      chk("hr_req1", {31'd0, imem_req}, 32'd1);
      tick();
      chk("hr_pc4", ID_pc4, 32'd4);
      chk("hr_ins", ID_instr, 32'hA000_0000);

      // 7. PC wrap at the top of the address space
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      chk("wr_addr0", imem_addr, 32'hFFFF_FFFC);
      tick();
      chk("wr_pc4",   ID_pc4, 32'h0);
      chk("wr_ins",   ID_instr, 32'hFFFF_FFFC);
      chk("wr_addr1", imem_addr, 32'h0);
      tick();
      chk("wr2_pc4", ID_pc4, 32'd4);
      chk("wr2_ins", ID_instr, 32'hA000_0000);

      // 8. redirect in HELD beats hold release; parked word is dropped
      set_hold(1'b1);
      tick();
      chk("hd_pc4", ID_pc4, 32'd4);
      set_hold(1'b0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h300;
      tick();
      redirect_valid = 1'b0;
      chk("hd_val",  {31'd0, ID_valid}, 32'd0);
      chk("hd_pc4b", ID_pc4, 32'd4);
      chk("hd_addr", imem_addr, 32'h300);
      tick();
      chk("hd2_pc4", ID_pc4, 32'h304);
      chk("hd2_ins", ID_instr, 32'hA000_0300);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
